// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access arbiter: op codes, FSM states, width defaults.
package regfile_pkg;
  localparam int DW_DEF  = 16;
  localparam int IDW_DEF = 6;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_READ   = 3'd1,
    OP_READU  = 3'd2,
    OP_WRITE  = 3'd3,
    OP_WRITEU = 3'd4,
    OP_INC    = 3'd5,
    OP_DEC    = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/regfile_arb_pick.sv
// Two-way tie breaker: a lone requester wins outright, a tie goes to the requester named by pointer.
module regfile_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic winner
);
  assign winner = (req0 && req1) ? pointer : (req1 && !req0);
endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester register-file access arbiter (IDLE -> ISSUE -> DONE per access).
// Define REGFILE_ARB_RR_EN for round-robin tie breaking; default build is fixed priority to requester 0.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [2:0]     op0,
  input  logic [2:0]     op1,
  input  logic [IDW-1:0] id0,
  input  logic [IDW-1:0] id1,
  input  logic [DW-1:0]  wdata0,
  input  logic [DW-1:0]  wdata1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [DW-1:0]  rdata,
  output logic           rf_read,
  output logic           rf_readu,
  output logic           rf_write,
  output logic           rf_writeu,
  output logic           rf_inc,
  output logic           rf_dec,
  output logic [IDW-1:0] rf_id,
  output logic [DW-1:0]  rf_din,
  input  logic [DW-1:0]  rf_dout
);
  state_e         state_q, state_d;
  op_e            op_q;
  logic [IDW-1:0] id_q;
  logic [DW-1:0]  wd_q, rdata_q;
  logic           win_q, winner, ptr, take;

  assign take = (state_q == ST_IDLE) && (req0 || req1);

`ifdef REGFILE_ARB_RR_EN
  // Pointer names the requester that wins the next tie: the one not granted last.
  logic ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst)       ptr_q <= 1'b0;
    else if (take) ptr_q <= ~winner;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  regfile_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .pointer (ptr),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req0 || req1) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Winner's request is captured once so the requester is free to change its inputs.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win_q <= 1'b0;
      op_q  <= OP_NOP;
      id_q  <= '0;
      wd_q  <= '0;
    end else if (take) begin
      win_q <= winner;
      op_q  <= winner ? op_e'(op1) : op_e'(op0);
      id_q  <= winner ? id1 : id0;
      wd_q  <= winner ? wdata1 : wdata0;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)
      rdata_q <= '0;
    else if (state_q == ST_ISSUE && (op_q == OP_READ || op_q == OP_READU))
      rdata_q <= rf_dout;

  // Outputs decode straight from the state register so reset clears them without a clock.
  logic issue;
  assign issue     = (state_q == ST_ISSUE);
  assign rf_read   = issue && (op_q == OP_READ);
  assign rf_readu  = issue && (op_q == OP_READU);
  assign rf_write  = issue && (op_q == OP_WRITE);
  assign rf_writeu = issue && (op_q == OP_WRITEU);
  assign rf_inc    = issue && (op_q == OP_INC);
  assign rf_dec    = issue && (op_q == OP_DEC);
  assign rf_id     = id_q;
  assign rf_din    = wd_q;
  assign rdata     = rdata_q;

  assign gnt0  = (state_q != ST_IDLE) && !win_q;
  assign gnt1  = (state_q != ST_IDLE) &&  win_q;
  assign done0 = (state_q == ST_DONE) && !win_q;
  assign done1 = (state_q == ST_DONE) &&  win_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter against a transaction-level model with an emulated register file.
module tb_regfile_arbiter;
  localparam int DW  = 16;
  localparam int IDW = 6;
  localparam int NREG = 1 << IDW;

  logic           clk = 1'b0, rst = 1'b1;
  logic           req0 = 0, req1 = 0;
  logic [2:0]     op0 = 0, op1 = 0;
  logic [IDW-1:0] id0 = 0, id1 = 0;
  logic [DW-1:0]  wdata0 = 0, wdata1 = 0;
  logic           gnt0, gnt1, done0, done1;
  logic [DW-1:0]  rdata, rf_din, rf_dout = 0;
  logic           rf_read, rf_readu, rf_write, rf_writeu, rf_inc, rf_dec;
  logic [IDW-1:0] rf_id;

  regfile_arbiter #(.DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .id0(id0), .id1(id1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .rf_read(rf_read), .rf_readu(rf_readu), .rf_write(rf_write),
    .rf_writeu(rf_writeu), .rf_inc(rf_inc), .rf_dec(rf_dec),
    .rf_id(rf_id), .rf_din(rf_din), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Model state: pending requests, emulated register file, expected rdata, last grant.
  bit            pend[2];
  logic [2:0]    p_op[2];
  logic [IDW-1:0] p_id[2];
  logic [DW-1:0] p_wd[2];
  logic [DW-1:0] regs[NREG];
  logic [DW-1:0] rdata_exp = '0;
  int            last_gnt = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {rf_read, rf_readu, rf_write, rf_writeu, rf_inc, rf_dec};
  endfunction

  // One-hot strobe expected for an op: READ is the MSB, DEC the LSB, NOP/7 none.
  function automatic logic [5:0] exp_strobe(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd6) return 6'b1 << (6 - int'(op));
    return 6'b0;
  endfunction

  function automatic int pick(input bit a, input bit b);
    if (a && !b) return 0;
    if (b && !a) return 1;
`ifdef REGFILE_ARB_RR_EN
    return (last_gnt == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic set_req(input int r, input logic [2:0] op, input logic [IDW-1:0] id,
                         input logic [DW-1:0] wd);
    pend[r] = 1; p_op[r] = op; p_id[r] = id; p_wd[r] = wd;
  endtask

  task automatic drive_pending();
    req0 = pend[0]; op0 = p_op[0]; id0 = p_id[0]; wdata0 = p_wd[0];
    req1 = pend[1]; op1 = p_op[1]; id1 = p_id[1]; wdata1 = p_wd[1];
  endtask

  // Entered 1 time unit after a posedge with the DUT in IDLE; leaves it the same way.
  task automatic arb_cycle();
    int w;
    logic [2:0] op; logic [IDW-1:0] id; logic [DW-1:0] wd;
    drive_pending();
    rf_dout = DW'($urandom);
    if (!pend[0] && !pend[1]) begin
      @(negedge clk);
      chk("idle_gnt", {gnt0, gnt1, done0, done1}, 4'b0);
      chk("idle_strb", strobes(), 6'b0);
      @(posedge clk); #1;
      return;
    end
    w = pick(pend[0], pend[1]);
    op = p_op[w]; id = p_id[w]; wd = p_wd[w];
    @(posedge clk); #1;
    op0 = 3'($urandom); id0 = IDW'($urandom); wdata0 = DW'($urandom);
    op1 = 3'($urandom); id1 = IDW'($urandom); wdata1 = DW'($urandom);
    rf_dout = regs[id];
    @(negedge clk);
    chk("iss_gnt", {gnt0, gnt1}, (w == 0) ? 2'b10 : 2'b01);
    chk("iss_done", {done0, done1}, 2'b00);
    chk("iss_strb", strobes(), exp_strobe(op));
    chk("iss_id", rf_id, id);
    chk("iss_din", rf_din, wd);
    @(posedge clk); #1;
    rf_dout = DW'($urandom);
    case (op)
      3'd1, 3'd2: rdata_exp = regs[id];
      3'd3, 3'd4: regs[id] = wd;
      3'd5:       regs[id] = regs[id] + 1'b1;
      3'd6:       regs[id] = regs[id] - 1'b1;
      default: ;
    endcase
    last_gnt = w;
    pend[w] = 0;
    @(negedge clk);
    chk("dn_gnt", {gnt0, gnt1}, (w == 0) ? 2'b10 : 2'b01);
    chk("dn_done", {done0, done1}, (w == 0) ? 2'b10 : 2'b01);
    chk("dn_strb", strobes(), 6'b0);
    chk("dn_rdata", rdata, rdata_exp);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = DW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {gnt0, gnt1, done0, done1, strobes()}, 10'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_id", {rf_id, rf_din}, '0);
    rst = 1'b0;

    // Write then read back through the other requester.
    set_req(0, 3'd3, 6'd5, 16'hBEEF); arb_cycle();
    set_req(1, 3'd1, 6'd5, 16'h0000); arb_cycle();
    chk("rd_beef", rdata, 16'hBEEF);
    set_req(0, 3'd5, 6'd3, 16'h1234); arb_cycle();
    set_req(1, 3'd6, 6'd3, 16'h4321); arb_cycle();
    set_req(0, 3'd7, 6'd9, 16'h5555); arb_cycle();
    chk("rsvd_rdata", rdata, 16'hBEEF);
    arb_cycle();

    // Continuous contention: the model decides the alternation or fixed order.
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r]) set_req(r, 3'($urandom_range(1, 6)), IDW'($urandom), DW'($urandom));
      arb_cycle();
    end

    for (int k = 0; k < 200; k++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 2) != 0)
          set_req(r, 3'($urandom), IDW'($urandom_range(0, 7)), DW'($urandom));
      arb_cycle();
    end
    while (pend[0] || pend[1]) arb_cycle();

    // Reset during ISSUE aborts the access outright.
    set_req(1, 3'd1, 6'd2, 16'h0); drive_pending();
    @(posedge clk); #1;
    rf_dout = 16'hA5A5;
    chk("pre_rst_gnt", gnt1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out", {gnt0, gnt1, done0, done1, strobes()}, 10'b0);
    chk("ar_rdata", rdata, '0);
    req0 = 0; req1 = 0; pend[1] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    rdata_exp = '0; last_gnt = 1;
    @(negedge clk);
    chk("ar_idle", {gnt0, gnt1, done0, done1, strobes()}, 10'b0);
    chk("ar_id", {rf_id, rf_din}, '0);
    @(posedge clk); #1;

    // Pointer favours requester 0 after reset.
    set_req(0, 3'd4, 6'd7, 16'hCAFE); set_req(1, 3'd2, 6'd7, 16'h0);
    arb_cycle(); arb_cycle();
    chk("post_rst_rd", rdata, 16'hCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
